// File: rtl/fm_pkg.sv
// Shared types and default geometry for the fm_nco_mod FM/PM modulator.
// Module parameters default to the DEF_* values below.
package fm_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_PHASE_W    = 32;
    localparam int DEF_LUT_ADDR_W = 10;
    localparam int DEF_AMP_LOG2   = 20;
    localparam int DEF_OUT_W      = 32;

    typedef logic [DEF_PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

    typedef enum logic {MODE_FM = 1'b0, MODE_PM = 1'b1} mode_e;

    typedef struct packed {
        logic   valid;
        phase_t phase;
        logic   neg;
    } stage_t;

endpackage

// File: rtl/fm_sine_lut_quarter.sv
// Quarter-wave sine ROM, table computed at elaboration, registered read with enable.
// Entry k = round(2^AMP_LOG2 * sin(pi/2 * (k + 0.5) / 2^ADDR_W)).
module fm_sine_lut_quarter #(
    parameter int ADDR_W   = 10,
    parameter int AMP_LOG2 = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [AMP_LOG2:0] o_data
);

    localparam int  DEPTH   = 1 << ADDR_W;
    localparam real HALF_PI = 1.5707963267948966;

    function automatic logic [AMP_LOG2:0] sine_entry(input int k);
        real x;
        x = (2.0 ** AMP_LOG2) * $sin(HALF_PI * (real'(k) + 0.5) / real'(DEPTH));
        return (AMP_LOG2 + 1)'($rtoi(x + 0.5));
    endfunction

    logic [AMP_LOG2:0] w_rom [DEPTH];
    logic [AMP_LOG2:0] r_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign w_rom[k] = sine_entry(k);
    end

    // NOTE: the table is a constant, so only the read register is reset, never the array.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_rom[i_addr];
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/fm_nco_mod.sv
// Streaming FM/PM modulator: scaled sample + carrier drive a phase accumulator,
// the phase is folded onto a quarter-wave sine ROM. Four enabled cycles of latency.
module fm_nco_mod
    import fm_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
    parameter int AMP_LOG2   = DEF_AMP_LOG2,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_in_valid,
    output logic               io_in_ready,
    input  logic [DATA_W-1:0]  io_in_value,
    input  logic [PHASE_W-1:0] io_cfg_carrier,
    input  logic [4:0]         io_cfg_shift,
    input  logic               io_cfg_mode,
    output logic               io_out_valid,
    input  logic               io_out_ready,
    output logic [OUT_W-1:0]   io_out_value
);

    logic                      w_en;
    logic signed [PHASE_W-1:0] w_in_ext;
    logic signed [PHASE_W-1:0] w_scaled;

    logic                      r_s0_valid;
    logic [PHASE_W-1:0]        r_s0_scaled;
    logic [PHASE_W-1:0]        r_s0_carrier;
    mode_e                     r_s0_mode;

    logic [PHASE_W-1:0]        r_acc;
    logic [PHASE_W-1:0]        w_acc_next;
    logic [PHASE_W-1:0]        w_s1_phase;
    logic                      r_s1_valid;
    logic [PHASE_W-1:0]        r_s1_phase;

    quad_e                     w_quad;
    logic [LUT_ADDR_W-1:0]     w_a;
    logic [LUT_ADDR_W-1:0]     w_addr;
    logic                      w_neg;
    logic                      w_unused_phase;

    logic                      r_s2_valid;
    logic                      r_s2_neg;
    logic [AMP_LOG2:0]         w_rom_data;
    logic [OUT_W-1:0]          w_rom_ext;

    logic                      r_out_valid;
    logic [OUT_W-1:0]          r_out_value;

    // A held output stalls every stage, so nothing in flight is lost or duplicated.
    assign w_en        = !r_out_valid || io_out_ready;
    assign io_in_ready = w_en;

    assign w_in_ext = PHASE_W'($signed(io_in_value));
    assign w_scaled = w_in_ext >>> io_cfg_shift;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s0_valid   <= 1'b0;
            r_s0_scaled  <= '0;
            r_s0_carrier <= '0;
            r_s0_mode    <= MODE_FM;
        end else if (w_en) begin
            r_s0_valid <= io_in_valid;
            if (io_in_valid) begin
                r_s0_scaled  <= w_scaled;
                r_s0_carrier <= io_cfg_carrier;
                r_s0_mode    <= mode_e'(io_cfg_mode);
            end
        end
    end

    // NOTE: defaults first so no path through always_comb leaves an output unassigned (no latch).
    always_comb begin
        w_s1_phase = r_acc;
        w_acc_next = r_acc + r_s0_carrier + r_s0_scaled;
        if (r_s0_mode == MODE_PM) begin
            w_s1_phase = r_acc + r_s0_scaled;
            w_acc_next = r_acc + r_s0_carrier;
        end
    end

    // Bubbles leave the accumulator untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_phase <= '0;
        end else if (w_en) begin
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_acc      <= w_acc_next;
                r_s1_phase <= w_s1_phase;
            end
        end
    end

    assign w_quad         = quad_e'(r_s1_phase[PHASE_W-1 -: 2]);
    assign w_a            = r_s1_phase[PHASE_W-3 -: LUT_ADDR_W];
    assign w_addr         = (w_quad == Q1 || w_quad == Q3) ? ~w_a : w_a;
    assign w_neg          = (w_quad == Q2 || w_quad == Q3);
    assign w_unused_phase = ^r_s1_phase;

    fm_sine_lut_quarter #(
        .ADDR_W   (LUT_ADDR_W),
        .AMP_LOG2 (AMP_LOG2)
    ) u_lut (
        .clock  (clock),
        .reset  (reset),
        .i_en   (w_en),
        .i_addr (w_addr),
        .o_data (w_rom_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_neg   <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_neg   <= w_neg;
        end
    end

    assign w_rom_ext = OUT_W'(w_rom_data);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_value <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_value <= r_s2_neg ? -w_rom_ext : w_rom_ext;
            end
        end
    end

    assign io_out_valid = r_out_valid;
    assign io_out_value = r_out_value;

endmodule

// File: tb/tb_fm_nco_mod.sv
// Directed bench for fm_nco_mod: hand-computed checkpoints plus a golden model
// of accumulator, fold and ROM compared against every delivered output sample.
module tb_fm_nco_mod;
    import fm_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_in_value;
    logic [31:0] io_cfg_carrier;
    logic [4:0]  io_cfg_shift;
    logic        io_cfg_mode;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_value;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     n_acc   = 0;
    phase_t m_acc   = '0;
    int     exp_q[$];
    int     out_log[$];

    fm_nco_mod dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_valid    (io_in_valid),
        .io_in_ready    (io_in_ready),
        .io_in_value    (io_in_value),
        .io_cfg_carrier (io_cfg_carrier),
        .io_cfg_shift   (io_cfg_shift),
        .io_cfg_mode    (io_cfg_mode),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_out_value   (io_out_value)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_out(input phase_t ph);
        logic [1:0] quad;
        logic [9:0] a;
        logic [9:0] addr;
        real        v;
        int         mag;
        quad = ph[31:30];
        a    = ph[29:20];
        addr = quad[0] ? ~a : a;
        v    = 1048576.0 * $sin(3.14159265358979 * (real'(addr) + 0.5) / 2048.0);
        mag  = $rtoi(v + 0.5);
        return quad[1] ? -mag : mag;
    endfunction

    task automatic model_accept();
        phase_t scaled;
        phase_t ph;
        scaled = phase_t'($signed(io_in_value) >>> io_cfg_shift);
        if (io_cfg_mode == MODE_PM) begin
            ph    = m_acc + scaled;
            m_acc = m_acc + io_cfg_carrier;
        end else begin
            ph    = m_acc;
            m_acc = m_acc + io_cfg_carrier + scaled;
        end
        exp_q.push_back(model_out(ph));
        n_acc++;
    endtask

    // Observe on the falling edge, then return just after the next rising edge.
    task automatic tick();
        int got;
        @(negedge clock);
        if (reset) begin
            if (io_in_valid && io_in_ready) model_accept();
            if (io_out_valid && io_out_ready) begin
                check("expected_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    got = int'($signed(io_out_value));
                    out_log.push_back(got);
                    check("stream", got, exp_q.pop_front());
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        m_acc        = '0;
        exp_q.delete();
        out_log.delete();
        tick();
        tick();
        reset = 1'b1;
        check("ready_after_reset", io_in_ready, 1);
    endtask

    task automatic drain();
        io_in_valid = 1'b0;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) tick();
        check("drained", exp_q.size(), 0);
    endtask

    task automatic run_stream(input int n);
        int start;
        start = n_acc;
        out_log.delete();
        io_in_valid = 1'b1;
        for (int c = 0; c < 200 && n_acc < start + n; c++) tick();
        check("accept_count", n_acc - start, n);
        drain();
    endtask

    initial begin
        // Reset held with a valid input pending.
        reset          = 1'b0;
        io_in_valid    = 1'b1;
        io_in_value    = 32'h1234_5678;
        io_cfg_carrier = 32'h1000_0000;
        io_cfg_shift   = 5'd0;
        io_cfg_mode    = 1'b0;
        io_out_ready   = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", io_out_valid, 0);
        check("rst_out_value", io_out_value, 0);
        io_in_valid = 1'b0;
        reset       = 1'b1;
        check("ready_after_release", io_in_ready, 1);

        // Carrier only: latency, then quarter-turn samples.
        io_in_value    = 32'h0;
        io_cfg_carrier = 32'h1000_0000;
        io_in_valid    = 1'b1;
        repeat (3) tick();
        check("latency_early", io_out_valid, 0);
        tick();
        check("latency_4", io_out_valid, 1);
        check("first_sample", $signed(io_out_value), 804);
        repeat (20) tick();
        check("carrier_s0", out_log[0], 804);
        check("carrier_s4", out_log[4], 1048576);
        check("carrier_s8", out_log[8], -804);
        check("carrier_s12", out_log[12], -1048576);
        check("carrier_s16", out_log[16], 804);

        // Backpressure mid-stream.
        io_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_in_ready", io_in_ready, 0);
            check("stall_out_valid", io_out_valid, 1);
            check("stall_out_value", $signed(io_out_value), exp_q[0]);
        end
        io_out_ready = 1'b1;
        repeat (12) tick();
        drain();

        // Deviation scaling, then an increment that wraps the accumulator back to itself.
        do_reset();
        io_cfg_carrier = 32'h0;
        io_in_value    = 32'h0010_0000;
        io_cfg_shift   = 5'd4;
        run_stream(3);
        check("dev_s0", out_log[0], 804);
        check("dev_s2", out_log[2], 804);
        io_cfg_shift   = 5'd0;
        io_cfg_carrier = 32'hF000_0000;
        io_in_value    = 32'h1000_0000;
        run_stream(3);
        check("wrap_s2", out_log[2], 804);
        do_reset();
        io_cfg_carrier = 32'h0;
        io_cfg_shift   = 5'd2;
        io_in_value    = 32'h1000_0000;
        run_stream(4);

        // Phase modulation, including an arithmetic shift of a negative sample.
        do_reset();
        io_cfg_mode    = 1'b1;
        io_cfg_carrier = 32'h0;
        io_cfg_shift   = 5'd0;
        io_in_value    = 32'h4000_0000;
        run_stream(1);
        check("pm_pos", out_log[0], 1048576);
        io_in_value = 32'hC000_0000;
        run_stream(1);
        check("pm_neg", out_log[0], -1048576);
        io_cfg_shift = 5'd1;
        io_in_value  = 32'h8000_0000;
        run_stream(1);
        check("pm_asr", out_log[0], -1048576);

        // Random valid/ready with per-cycle config changes.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            io_in_valid    = 1'($urandom_range(0, 1));
            io_out_ready   = ($urandom_range(0, 3) != 0);
            io_in_value    = $urandom;
            io_cfg_carrier = $urandom;
            io_cfg_shift   = 5'($urandom_range(0, 31));
            io_cfg_mode    = 1'($urandom_range(0, 1));
            tick();
        end
        io_out_ready = 1'b1;
        drain();

        // Reset while output is valid, then restart of the carrier sequence.
        io_cfg_mode    = 1'b0;
        io_cfg_shift   = 5'd0;
        io_cfg_carrier = 32'h1000_0000;
        io_in_value    = 32'h0;
        io_in_valid    = 1'b1;
        repeat (8) tick();
        check("pre_reset_valid", io_out_valid, 1);
        reset = 1'b0;
        #1;
        check("async_flush_valid", io_out_valid, 0);
        check("async_flush_value", io_out_value, 0);
        m_acc = '0;
        exp_q.delete();
        out_log.delete();
        repeat (2) tick();
        reset = 1'b1;
        run_stream(8);
        check("restart_s0", out_log[0], 804);
        check("restart_s4", out_log[4], 1048576);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
